datapath_ctrl: RTL and testbench

Microcoded-style Moore control unit that drives the group's 16-bit `datapath`. It consumes the decoded instruction fields `ir_1`, `ir_2` and `funct` and produces every load and tri-state enable the datapath expects. It also handshakes with memory through `mem_rd`/`mem_wr`/`mem_ready`. It sits between the datapath and the memory model and closes the fetch–decode–execute loop.

---
 rtl/datapath_ctrl_if.sv | 35 +++
 rtl/datapath_ctrl.sv | 142 ++++++++++++++
 tb/tb_datapath_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_if.sv
// Control/status bundle between datapath_ctrl and the datapath + memory model.
// The controller uses the master modport; the datapath/memory side uses slave.
interface datapath_ctrl_if;
  logic [3:0] ir_1;
  logic [1:0] ir_2;
  logic [2:0] funct;
  logic       mem_ready;

  logic       ldMDR, ldMAR, ldIR, ldALUreg, ldSP, ldPC, ldReg;
  logic       Tmdr, Tlabel, Tpc, Tsp, Treg;
  logic       ALUon;
  logic [2:0] fnSelect;
  logic       mm;
  logic       pc_inc, sp_inc, sp_dec;
  logic       mem_rd, mem_wr;
  logic       halted, illegal;

  modport master (
    input  ir_1, ir_2, funct, mem_ready,
    output ldMDR, ldMAR, ldIR, ldALUreg, ldSP, ldPC, ldReg,
    output Tmdr, Tlabel, Tpc, Tsp, Treg,
    output ALUon, fnSelect, mm,
    output pc_inc, sp_inc, sp_dec,
    output mem_rd, mem_wr, halted, illegal
  );

  modport slave (
    output ir_1, ir_2, funct, mem_ready,
    input  ldMDR, ldMAR, ldIR, ldALUreg, ldSP, ldPC, ldReg,
    input  Tmdr, Tlabel, Tpc, Tsp, Treg,
    input  ALUon, fnSelect, mm,
    input  pc_inc, sp_inc, sp_dec,
    input  mem_rd, mem_wr, halted, illegal
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Moore fetch-decode-execute controller for the 16-bit datapath.
// A 3-bit op register, loaded in DEC, steers the states shared between instructions.
module datapath_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  datapath_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_RST, S_FA, S_FM, S_FI, S_DEC, S_AEX, S_AWB, S_MA,
    S_MR, S_MWB, S_WD, S_MW, S_SPA, S_JMP, S_HLT, S_ILL
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_ALU, OP_LOAD, OP_STORE, OP_PUSH, OP_POP, OP_JMP
  } op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      op_q    <= OP_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    bus.ldMDR    = 1'b0;
    bus.ldMAR    = 1'b0;
    bus.ldIR     = 1'b0;
    bus.ldALUreg = 1'b0;
    bus.ldSP     = 1'b0;
    bus.ldPC     = 1'b0;
    bus.ldReg    = 1'b0;
    bus.Tmdr     = 1'b0;
    bus.Tlabel   = 1'b0;
    bus.Tpc      = 1'b0;
    bus.Tsp      = 1'b0;
    bus.Treg     = 1'b0;
    bus.ALUon    = 1'b0;
    bus.fnSelect = 3'b000;
    bus.mm       = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.sp_inc   = 1'b0;
    bus.sp_dec   = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.halted   = 1'b0;
    bus.illegal  = 1'b0;

    case (state_q)
      S_RST: state_d = S_FA;
      S_FA: begin
        bus.Tpc   = 1'b1;
        bus.ldMAR = 1'b1;
        state_d   = S_FM;
      end
      S_FM: begin
        bus.mem_rd = 1'b1;
        bus.ldMDR  = 1'b1;
        if (bus.mem_ready) state_d = S_FI;
      end
      S_FI: begin
        bus.Tmdr   = 1'b1;
        bus.ldIR   = 1'b1;
        bus.pc_inc = 1'b1;
        state_d    = S_DEC;
      end
      S_DEC: begin
        case (bus.ir_1)
          4'b0000: begin state_d = S_AEX; op_d = OP_ALU;   end
          4'b0010: begin state_d = S_MA;  op_d = OP_LOAD;  end
          4'b0011: begin state_d = S_MA;  op_d = OP_STORE; end
          4'b0100: begin state_d = S_SPA; op_d = OP_PUSH;  end
          4'b0101: begin state_d = S_SPA; op_d = OP_POP;   end
          4'b0110: begin state_d = S_JMP; op_d = OP_JMP;   end
          4'b1111: begin state_d = S_HLT; op_d = OP_NONE;  end
          default: begin state_d = S_ILL; op_d = OP_NONE;  end
        endcase
      end
      S_AEX: begin
        bus.ALUon    = 1'b1;
        bus.ldALUreg = 1'b1;
        bus.fnSelect = bus.funct;
        bus.mm       = bus.ir_2[0];
        state_d      = S_AWB;
      end
      S_AWB: begin
        bus.Treg  = 1'b1;
        bus.ldReg = 1'b1;
        state_d   = S_FA;
      end
      S_MA: begin
        bus.Tlabel = 1'b1;
        bus.ldMAR  = 1'b1;
        state_d    = (op_q == OP_LOAD) ? S_MR : S_WD;
      end
      // SP is stepped and latched into MAR in the same cycle, so MAR sees the old SP.
      S_SPA: begin
        bus.Tsp    = 1'b1;
        bus.ldMAR  = 1'b1;
        bus.sp_dec = (op_q == OP_PUSH);
        bus.sp_inc = (op_q == OP_POP);
        state_d    = (op_q == OP_PUSH) ? S_WD : S_MR;
      end
      S_MR: begin
        bus.mem_rd = 1'b1;
        bus.ldMDR  = 1'b1;
        if (bus.mem_ready) state_d = S_MWB;
      end
      S_MWB: begin
        bus.Tmdr  = 1'b1;
        bus.ldReg = 1'b1;
        state_d   = S_FA;
      end
      S_WD: begin
        bus.Treg  = 1'b1;
        bus.ldMDR = 1'b1;
        state_d   = S_MW;
      end
      S_MW: begin
        bus.mem_wr = 1'b1;
        if (bus.mem_ready) state_d = S_FA;
      end
      S_JMP: begin
        bus.Tlabel = 1'b1;
        bus.ldPC   = 1'b1;
        state_d    = S_FA;
      end
      S_HLT: bus.halted = 1'b1;
      S_ILL: bus.illegal = 1'b1;
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: each cycle's expected output vector is queued
// alongside the stimulus and popped for comparison at the falling edge.
module tb_datapath_ctrl;

  typedef struct packed {
    logic       ldMDR, ldMAR, ldIR, ldALUreg, ldSP, ldPC, ldReg;
    logic       Tmdr, Tlabel, Tpc, Tsp, Treg;
    logic       ALUon;
    logic [2:0] fnSelect;
    logic       mm, pc_inc, sp_inc, sp_dec, mem_rd, mem_wr, halted, illegal;
  } outs_t;

  typedef struct {
    string tag;
    outs_t exp;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  sb_entry_t sbQ[$];
  outs_t     obs;

  datapath_ctrl_if bus();

  datapath_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.ldMDR, bus.ldMAR, bus.ldIR, bus.ldALUreg, bus.ldSP, bus.ldPC, bus.ldReg,
                bus.Tmdr, bus.Tlabel, bus.Tpc, bus.Tsp, bus.Treg, bus.ALUon, bus.fnSelect,
                bus.mm, bus.pc_inc, bus.sp_inc, bus.sp_dec, bus.mem_rd, bus.mem_wr,
                bus.halted, bus.illegal};

  // Expected outputs for each controller state, straight from the state table.
  function automatic outs_t expOut(input string st, input logic [2:0] fn, input logic m);
    outs_t o;
    o = '0;
    case (st)
      "FA":       begin o.Tpc = 1'b1; o.ldMAR = 1'b1; end
      "FM":       begin o.mem_rd = 1'b1; o.ldMDR = 1'b1; end
      "FI":       begin o.Tmdr = 1'b1; o.ldIR = 1'b1; o.pc_inc = 1'b1; end
      "AEX":      begin o.ALUon = 1'b1; o.ldALUreg = 1'b1; o.fnSelect = fn; o.mm = m; end
      "AWB":      begin o.Treg = 1'b1; o.ldReg = 1'b1; end
      "MA":       begin o.Tlabel = 1'b1; o.ldMAR = 1'b1; end
      "MR":       begin o.mem_rd = 1'b1; o.ldMDR = 1'b1; end
      "MWB":      begin o.Tmdr = 1'b1; o.ldReg = 1'b1; end
      "WD":       begin o.Treg = 1'b1; o.ldMDR = 1'b1; end
      "MW":       begin o.mem_wr = 1'b1; end
      "SPA_PUSH": begin o.Tsp = 1'b1; o.ldMAR = 1'b1; o.sp_dec = 1'b1; end
      "SPA_POP":  begin o.Tsp = 1'b1; o.ldMAR = 1'b1; o.sp_inc = 1'b1; end
      "JMP":      begin o.Tlabel = 1'b1; o.ldPC = 1'b1; end
      "HLT":      begin o.halted = 1'b1; end
      "ILL":      begin o.illegal = 1'b1; end
      default:    o = '0;
    endcase
    return o;
  endfunction

  task automatic applyStimulus(input string tag, input string st, input logic rdy,
                               input logic [2:0] fn, input logic m);
    sb_entry_t e;
    e.tag = tag;
    e.exp = expOut(st, fn, m);
    sbQ.push_back(e);
    bus.mem_ready = rdy;
  endtask

  task automatic checkOutput();
    sb_entry_t e;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed=%h expected=queued entry", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
    checks++;
    assert ($onehot0({bus.Tmdr, bus.Tlabel, bus.Tpc, bus.Tsp, bus.Treg}) &&
            !(bus.mem_rd && bus.mem_wr)) else begin
      errors++;
      $error("[TB] FAIL exclusivity: observed bus=%b rd/wr=%b%b expected onehot0 and not both",
             {bus.Tmdr, bus.Tlabel, bus.Tpc, bus.Tsp, bus.Treg}, bus.mem_rd, bus.mem_wr);
    end
  endtask

  task automatic step(input string tag, input string st, input logic rdy,
                      input logic [2:0] fn = 3'b000, input logic m = 1'b0);
    applyStimulus(tag, st, rdy, fn, m);
    checkOutput();
    @(negedge clk);
  endtask

  task automatic setIr(input logic [3:0] op, input logic [1:0] mode, input logic [2:0] fn);
    bus.ir_1  = op;
    bus.ir_2  = mode;
    bus.funct = fn;
  endtask

  initial begin
    rst_n = 1'b1;
    setIr(4'b0000, 2'b00, 3'b000);
    bus.mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    step("reset_hold", "RST", 1'b1);
    rst_n = 1'b1;
    step("reset_release", "RST", 1'b0);

    // Fetch interrupted by an asynchronous reset while waiting on memory.
    step("fetch_fa", "FA", 1'b0);
    step("fetch_wait", "FM", 1'b0);
    applyStimulus("fm_before_reset", "FM", 1'b0, 3'b000, 1'b0);
    checkOutput();
    #2 rst_n = 1'b0;
    #1;
    applyStimulus("async_reset", "RST", 1'b0, 3'b000, 1'b0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", "RST", 1'b1);

    // ALU, zero-wait: FA..AWB is 6 cycles.
    setIr(4'b0000, 2'b01, 3'b100);
    step("alu1_fa", "FA", 1'b1);
    step("alu1_fm", "FM", 1'b1);
    step("alu1_fi", "FI", 1'b1);
    step("alu1_dec", "DEC", 1'b1);
    step("alu1_aex", "AEX", 1'b1, 3'b100, 1'b1);
    step("alu1_awb", "AWB", 1'b1);

    // LOAD with three wait cycles in MR: 10 cycles.
    setIr(4'b0010, 2'b00, 3'b000);
    step("load_fa", "FA", 1'b1);
    step("load_fm", "FM", 1'b1);
    step("load_fi", "FI", 1'b1);
    step("load_dec", "DEC", 1'b1);
    step("load_ma", "MA", 1'b0);
    step("load_mr0", "MR", 1'b0);
    step("load_mr1", "MR", 1'b0);
    step("load_mr2", "MR", 1'b0);
    step("load_mr3", "MR", 1'b1);
    step("load_mwb", "MWB", 1'b0);

    // STORE with one fetch wait cycle.
    setIr(4'b0011, 2'b00, 3'b000);
    step("store_fa", "FA", 1'b0);
    step("store_fm0", "FM", 1'b0);
    step("store_fm1", "FM", 1'b1);
    step("store_fi", "FI", 1'b1);
    step("store_dec", "DEC", 1'b1);
    step("store_ma", "MA", 1'b1);
    step("store_wd", "WD", 1'b1);
    step("store_mw", "MW", 1'b1);

    setIr(4'b0100, 2'b00, 3'b000);
    step("push_fa", "FA", 1'b1);
    step("push_fm", "FM", 1'b1);
    step("push_fi", "FI", 1'b1);
    step("push_dec", "DEC", 1'b1);
    step("push_spa", "SPA_PUSH", 1'b1);
    step("push_wd", "WD", 1'b1);
    step("push_mw0", "MW", 1'b0);
    step("push_mw1", "MW", 1'b1);

    setIr(4'b0101, 2'b00, 3'b000);
    step("pop_fa", "FA", 1'b1);
    step("pop_fm", "FM", 1'b1);
    step("pop_fi", "FI", 1'b1);
    step("pop_dec", "DEC", 1'b1);
    step("pop_spa", "SPA_POP", 1'b1);
    step("pop_mr", "MR", 1'b1);
    step("pop_mwb", "MWB", 1'b1);

    setIr(4'b0110, 2'b00, 3'b000);
    step("jmp_fa", "FA", 1'b1);
    step("jmp_fm", "FM", 1'b1);
    step("jmp_fi", "FI", 1'b1);
    step("jmp_dec", "DEC", 1'b1);
    step("jmp_jmp", "JMP", 1'b1);

    // Second ALU pattern: mm follows ir_2[0]=0.
    setIr(4'b0000, 2'b10, 3'b011);
    step("alu2_fa", "FA", 1'b1);
    step("alu2_fm", "FM", 1'b1);
    step("alu2_fi", "FI", 1'b1);
    step("alu2_dec", "DEC", 1'b1);
    step("alu2_aex", "AEX", 1'b1, 3'b011, 1'b0);
    step("alu2_awb", "AWB", 1'b1);

    setIr(4'b1111, 2'b11, 3'b111);
    step("halt_fa", "FA", 1'b1);
    step("halt_fm", "FM", 1'b1);
    step("halt_fi", "FI", 1'b1);
    step("halt_dec", "DEC", 1'b1);
    for (int i = 0; i < 20; i++) begin
      step("halt_hold", "HLT", i[0]);
    end

    rst_n = 1'b0;
    #1;
    applyStimulus("halt_reset", "RST", 1'b0, 3'b000, 1'b0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    setIr(4'b1010, 2'b00, 3'b000);
    step("ill_rst", "RST", 1'b1);
    step("ill_fa", "FA", 1'b1);
    step("ill_fm", "FM", 1'b1);
    step("ill_fi", "FI", 1'b1);
    step("ill_dec", "DEC", 1'b1);
    for (int i = 0; i < 10; i++) begin
      step("ill_hold", "ILL", i[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    applyStimulus("ill_reset", "RST", 1'b0, 3'b000, 1'b0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
